// File: rtl/matrix_sweep_ctrl.sv
// Purpose: walks a ROWS x COLS matrix (full or upper-triangular) and emits one (row, col, idx) beat per transfer.
// Latency: first beat is valid one cycle after start is accepted; done pulses one cycle after the final transfer.
// Backpressure: with valid=1 and ready=0 the beat holds stable; valid never depends combinationally on ready.
module matrix_sweep_ctrl #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1,
  parameter int COL_W = (COLS > 1) ? $clog2(COLS) : 1,
  parameter int IDX_W = ((ROWS * COLS) > 1) ? $clog2(ROWS * COLS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             tri_mode,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             valid,
  input  logic             ready,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic [IDX_W-1:0] idx,
  output logic             last
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);

  state_t           state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             tri_q, tri_d;
  logic [ROW_W-1:0] row_inc;
  logic             at_end;

  // State and coordinate registers; everything returns to zero on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      idx_q   <= '0;
      tri_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      idx_q   <= idx_d;
      tri_q   <= tri_d;
    end
  end

  // Next-state, coordinate stepping and registered-state-derived outputs.
  // Coordinates are cleared whenever the sweep ends so the row counter never
  // steps past ROWS-1 and IDLE always presents zeros.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    idx_d   = idx_q;
    tri_d   = tri_q;
    row_inc = row_q + ROW_W'(1);
    at_end  = (row_q == ROW_MAX) && (col_q == COL_MAX);

    busy  = (state_q == RUN);
    valid = (state_q == RUN);
    done  = (state_q == DONE);
    last  = (state_q == RUN) && at_end;
    row   = row_q;
    col   = col_q;
    idx   = idx_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          tri_d   = tri_mode;
          row_d   = '0;
          col_d   = '0;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // abort wins over a coincident transfer: the sweep ends without done
        if (abort) begin
          state_d = IDLE;
          row_d   = '0;
          col_d   = '0;
          idx_d   = '0;
        end else if (ready) begin
          if (at_end) begin
            state_d = DONE;
            row_d   = '0;
            col_d   = '0;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
            if (col_q != COL_MAX) begin
              col_d = col_q + COL_W'(1);
            end else begin
              row_d = row_inc;
              // triangular rows start on the diagonal of the new row
              col_d = tri_q ? COL_W'(row_inc) : '0;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_matrix_sweep_ctrl.sv
module tb_matrix_sweep_ctrl;

  logic clk;
  logic rst;
  logic start_a, start_b, start_c;
  logic tri_mode;
  logic abort;
  logic ready;

  // 4x3 instance
  logic       busy_a, done_a, valid_a, last_a;
  logic [1:0] row_a, col_a;
  logic [3:0] idx_a;
  // 4x4 instance (triangular)
  logic       busy_b, done_b, valid_b, last_b;
  logic [1:0] row_b, col_b;
  logic [3:0] idx_b;
  // 1x1 instance
  logic       busy_c, done_c, valid_c, last_c;
  logic [0:0] row_c, col_c, idx_c;

  int vectors;
  int miscompares;

  matrix_sweep_ctrl #(.ROWS(4), .COLS(3)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .tri_mode(tri_mode), .abort(abort),
    .busy(busy_a), .done(done_a), .valid(valid_a), .ready(ready),
    .row(row_a), .col(col_a), .idx(idx_a), .last(last_a)
  );

  matrix_sweep_ctrl #(.ROWS(4), .COLS(4)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .tri_mode(tri_mode), .abort(abort),
    .busy(busy_b), .done(done_b), .valid(valid_b), .ready(ready),
    .row(row_b), .col(col_b), .idx(idx_b), .last(last_b)
  );

  matrix_sweep_ctrl #(.ROWS(1), .COLS(1)) u_dut_c (
    .clk(clk), .rst(rst), .start(start_c), .tri_mode(tri_mode), .abort(abort),
    .busy(busy_c), .done(done_c), .valid(valid_c), .ready(ready),
    .row(row_c), .col(col_c), .idx(idx_c), .last(last_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed status words, packed as {valid, busy, done, last, row, col, idx}
  function automatic logic [11:0] obs_a();
    return {valid_a, busy_a, done_a, last_a, row_a, col_a, idx_a};
  endfunction

  function automatic logic [11:0] obs_b();
    return {valid_b, busy_b, done_b, last_b, row_b, col_b, idx_b};
  endfunction

  function automatic logic [6:0] obs_c();
    return {valid_c, busy_c, done_c, last_c, row_c, col_c, idx_c};
  endfunction

  task automatic test_reset();
    @(negedge clk);
    vectors++;
    if (obs_a() !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_a got %h exp %h", obs_a(), 12'h000);
    end
    vectors++;
    if (obs_b() !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_b got %h exp %h", obs_b(), 12'h000);
    end
    vectors++;
    if (obs_c() !== 7'h00) begin
      miscompares++;
      $display("FAIL reset_c got %h exp %h", obs_c(), 7'h00);
    end
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (obs_a() !== 12'h000) begin
      miscompares++;
      $display("FAIL idle_after_reset got %h exp %h", obs_a(), 12'h000);
    end
  endtask

  task automatic test_full_sweep();
    logic [11:0] exp;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int b = 0; b < 12; b++) begin
      exp = {1'b1, 1'b1, 1'b0, (b == 11), 2'(b / 3), 2'(b % 3), 4'(b)};
      vectors++;
      if (obs_a() !== exp) begin
        miscompares++;
        $display("FAIL full_beat%0d got %h exp %h", b, obs_a(), exp);
      end
      @(negedge clk);
    end
    vectors++;
    if (obs_a() !== 12'h200) begin
      miscompares++;
      $display("FAIL full_done got %h exp %h", obs_a(), 12'h200);
    end
    @(negedge clk);
    vectors++;
    if (obs_a() !== 12'h000) begin
      miscompares++;
      $display("FAIL full_idle got %h exp %h", obs_a(), 12'h000);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rpat;
    logic [11:0] exp;
    int b;
    int hold;
    int lows;
    rpat = 32'b1011_0010_1101_1100_0111_0101_1010_0110;
    b    = 0;
    hold = 0;
    lows = 0;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int cyc = 0; cyc < 100 && b < 12; cyc++) begin
      exp = {1'b1, 1'b1, 1'b0, (b == 11), 2'(b / 3), 2'(b % 3), 4'(b)};
      vectors++;
      if (obs_a() !== exp) begin
        miscompares++;
        $display("FAIL bp_cyc%0d got %h exp %h", cyc, obs_a(), exp);
      end
      if (b == 5 && hold < 3) begin
        ready = 1'b0;
        hold++;
      end else begin
        ready = rpat[cyc % 32];
      end
      if (!ready) lows++;
      @(negedge clk);
      if (ready) b++;
    end
    ready = 1'b1;
    vectors++;
    if (b != 12) begin
      miscompares++;
      $display("FAIL bp_timeout got %0d beats exp %0d", b, 12);
    end
    vectors++;
    if (obs_a() !== 12'h200) begin
      miscompares++;
      $display("FAIL bp_done got %h exp %h (ready-low cycles %0d)", obs_a(), 12'h200, lows);
    end
    @(negedge clk);
  endtask

  task automatic test_triangular();
    int tr_row[10] = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 3};
    int tr_col[10] = '{0, 1, 2, 3, 1, 2, 3, 2, 3, 3};
    logic [11:0] exp;
    tri_mode = 1'b1;
    start_b  = 1'b1;
    @(negedge clk);
    start_b  = 1'b0;
    tri_mode = 1'b0;
    for (int b = 0; b < 10; b++) begin
      exp = {1'b1, 1'b1, 1'b0, (b == 9), 2'(tr_row[b]), 2'(tr_col[b]), 4'(b)};
      vectors++;
      if (obs_b() !== exp) begin
        miscompares++;
        $display("FAIL tri_beat%0d got %h exp %h", b, obs_b(), exp);
      end
      @(negedge clk);
    end
    vectors++;
    if (obs_b() !== 12'h200) begin
      miscompares++;
      $display("FAIL tri_done got %h exp %h", obs_b(), 12'h200);
    end
    @(negedge clk);
  endtask

  task automatic test_start_handling();
    logic [11:0] exp;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int b = 0; b < 12; b++) begin
      exp = {1'b1, 1'b1, 1'b0, (b == 11), 2'(b / 3), 2'(b % 3), 4'(b)};
      vectors++;
      if (obs_a() !== exp) begin
        miscompares++;
        $display("FAIL start_beat%0d got %h exp %h", b, obs_a(), exp);
      end
      start_a = (b == 5);
      @(negedge clk);
    end
    vectors++;
    if (obs_a() !== 12'h200) begin
      miscompares++;
      $display("FAIL start_done got %h exp %h", obs_a(), 12'h200);
    end
    start_a = 1'b1;
    @(negedge clk);
    vectors++;
    if (obs_a() !== 12'h000) begin
      miscompares++;
      $display("FAIL start_in_done got %h exp %h", obs_a(), 12'h000);
    end
    @(negedge clk);
    start_a = 1'b0;
    vectors++;
    if (obs_a() !== 12'hC00) begin
      miscompares++;
      $display("FAIL start_after_done got %h exp %h", obs_a(), 12'hC00);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic test_abort();
    logic [11:0] exp;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int b = 0; b <= 7; b++) begin
      exp = {1'b1, 1'b1, 1'b0, 1'b0, 2'(b / 3), 2'(b % 3), 4'(b)};
      vectors++;
      if (obs_a() !== exp) begin
        miscompares++;
        $display("FAIL abort_beat%0d got %h exp %h", b, obs_a(), exp);
      end
      if (b == 7) abort = 1'b1;
      @(negedge clk);
    end
    abort = 1'b0;
    vectors++;
    if (obs_a() !== 12'h000) begin
      miscompares++;
      $display("FAIL abort_idle got %h exp %h", obs_a(), 12'h000);
    end
    @(negedge clk);
    vectors++;
    if (obs_a() !== 12'h000) begin
      miscompares++;
      $display("FAIL abort_no_done got %h exp %h", obs_a(), 12'h000);
    end
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    vectors++;
    if (obs_a() !== 12'hC00) begin
      miscompares++;
      $display("FAIL abort_restart got %h exp %h", obs_a(), 12'hC00);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic test_async_reset();
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (obs_a() !== 12'hC43) begin
      miscompares++;
      $display("FAIL arst_pre got %h exp %h", obs_a(), 12'hC43);
    end
    #2 rst = 1'b0;
    #1;
    vectors++;
    if (obs_a() !== 12'h000) begin
      miscompares++;
      $display("FAIL arst_immediate got %h exp %h", obs_a(), 12'h000);
    end
    @(negedge clk);
    #3 rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (obs_a() !== 12'h000) begin
      miscompares++;
      $display("FAIL arst_idle got %h exp %h", obs_a(), 12'h000);
    end
    @(negedge clk);
    vectors++;
    if (obs_a() !== 12'h000) begin
      miscompares++;
      $display("FAIL arst_no_done got %h exp %h", obs_a(), 12'h000);
    end
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    vectors++;
    if (obs_a() !== 12'hC00) begin
      miscompares++;
      $display("FAIL arst_restart got %h exp %h", obs_a(), 12'hC00);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic test_one_by_one();
    start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    vectors++;
    if (obs_c() !== 7'b1101_000) begin
      miscompares++;
      $display("FAIL one_beat got %b exp %b", obs_c(), 7'b1101_000);
    end
    @(negedge clk);
    vectors++;
    if (obs_c() !== 7'b0010_000) begin
      miscompares++;
      $display("FAIL one_done got %b exp %b", obs_c(), 7'b0010_000);
    end
    @(negedge clk);
    vectors++;
    if (obs_c() !== 7'b0000_000) begin
      miscompares++;
      $display("FAIL one_idle got %b exp %b", obs_c(), 7'b0000_000);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst      = 1'b0;
    start_a  = 1'b0;
    start_b  = 1'b0;
    start_c  = 1'b0;
    tri_mode = 1'b0;
    abort    = 1'b0;
    ready    = 1'b1;
    test_reset();
    test_full_sweep();
    test_backpressure();
    test_triangular();
    test_start_handling();
    test_abort();
    test_async_reset();
    test_one_by_one();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
